// File: rtl/wam_pkg.sv
// Shared whack-a-mole definitions: judging FSM encoding and default widths.
package wam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_LIGHT = 3'd1,
    ST_LIT        = 3'd2,
    ST_HIT_HOLD   = 3'd3,
    ST_OVER       = 3'd4
  } state_t;

  localparam int unsigned CNT_W_DEF   = 6;
  localparam int unsigned KEY_W_DEF   = 4;
  localparam int unsigned LIVES_W_DEF = 2;

endpackage

// File: rtl/edge_detect.sv
// Registers a level and reports its rising and falling edges for the current cycle.
module edge_detect (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic r_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_q <= 1'b0;
    end else if (clear) begin
      r_q <= 1'b0;
    end else begin
      r_q <= d;
    end
  end

  assign rise = d & ~r_q;
  assign fall = ~d & r_q;

endmodule

// File: rtl/score_keeper.sv
// Judges keypad presses against the lit mole; keeps points, flicks and lives and flags game over.
module score_keeper
  import wam_pkg::*;
#(
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned KEY_W          = KEY_W_DEF,
  parameter int unsigned LIVES_W        = LIVES_W_DEF,
  parameter bit          PENALIZE_EARLY = 1'b0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clear,
  input  logic               start_game,
  input  logic               light_on,
  input  logic [KEY_W-1:0]   light_coord,
  input  logic               valid_key,
  input  logic [KEY_W-1:0]   key,
  input  logic [CNT_W-1:0]   max_hits,
  input  logic [LIVES_W-1:0] total_lives,
  output logic [CNT_W-1:0]   total_points,
  output logic [CNT_W-1:0]   light_flicks,
  output logic [LIVES_W-1:0] lives_left,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               gameover
);

  localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [LIVES_W-1:0] LIV_ONE = {{(LIVES_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [LIVES_W-1:0] sat_dec(input logic [LIVES_W-1:0] v);
    return (v == '0) ? v : v - LIV_ONE;
  endfunction

  state_t             r_state, w_state_n;
  logic [CNT_W-1:0]   r_points, w_points_n;
  logic [CNT_W-1:0]   r_flicks, w_flicks_n;
  logic [LIVES_W-1:0] r_lives, w_lives_n;
  logic [KEY_W-1:0]   r_target, w_target_n;
  logic               r_hit, w_hit_n;
  logic               r_miss, w_miss_n;
  logic               w_rise, w_fall;
  logic               w_miss, w_flick;

  edge_detect u_edge (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear),
    .d      (light_on),
    .rise   (w_rise),
    .fall   (w_fall)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_points <= '0;
      r_flicks <= '0;
      r_lives  <= '0;
      r_target <= '0;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
    end else if (clear) begin
      r_state  <= ST_IDLE;
      r_points <= '0;
      r_flicks <= '0;
      r_lives  <= '0;
      r_target <= '0;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_points <= w_points_n;
      r_flicks <= w_flicks_n;
      r_lives  <= w_lives_n;
      r_target <= w_target_n;
      r_hit    <= w_hit_n;
      r_miss   <= w_miss_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_points_n = r_points;
    w_flicks_n = r_flicks;
    w_lives_n  = r_lives;
    w_target_n = r_target;
    w_hit_n    = 1'b0;
    w_miss_n   = 1'b0;
    w_miss     = 1'b0;
    w_flick    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (start_game) begin
          w_lives_n = total_lives;
          w_state_n = ST_WAIT_LIGHT;
        end
      end
      ST_WAIT_LIGHT: begin
        // A key on the rise cycle belongs to neither the old nor the new light.
        if (start_game) begin
          if (w_rise) begin
            w_target_n = light_coord;
            w_state_n  = ST_LIT;
          end else if (valid_key && PENALIZE_EARLY) begin
            w_miss = 1'b1;
          end
        end
      end
      ST_LIT: begin
        if (start_game) begin
          if (valid_key) begin
            if (key == r_target) begin
              w_hit_n    = 1'b1;
              w_points_n = sat_inc(r_points);
            end else begin
              w_miss = 1'b1;
            end
            w_state_n = ST_HIT_HOLD;
          end
          if (w_fall) begin
            if (!valid_key) w_miss = 1'b1;
            w_flick = 1'b1;
          end
        end
      end
      ST_HIT_HOLD: begin
        if (start_game && w_fall) w_flick = 1'b1;
      end
      ST_OVER: begin
      end
      default: w_state_n = ST_IDLE;
    endcase

    if (w_flick) begin
      w_flicks_n = sat_inc(r_flicks);
      if ((max_hits != '0) && (w_flicks_n == max_hits)) w_state_n = ST_OVER;
      else                                              w_state_n = ST_WAIT_LIGHT;
    end

    // Running out of lives overrides whatever the flick update chose.
    if (w_miss) begin
      w_miss_n = 1'b1;
      if (total_lives != '0) begin
        w_lives_n = sat_dec(r_lives);
        if (w_lives_n == '0) w_state_n = ST_OVER;
      end
    end
  end

  assign total_points = r_points;
  assign light_flicks = r_flicks;
  assign lives_left   = r_lives;
  assign hit_pulse    = r_hit;
  assign miss_pulse   = r_miss;
  assign gameover     = (r_state == ST_OVER);

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench: stimulus queues each expected output change, a negedge monitor checks them.
module tb_score_keeper;

  typedef struct packed {
    logic       hit;
    logic       miss;
    logic [5:0] pts;
    logic [5:0] flk;
    logic [1:0] liv;
    logic       go;
  } obs_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       clear;
  logic       start_game;
  logic       light_on;
  logic [3:0] light_coord;
  logic       valid_key;
  logic [3:0] key;
  logic [5:0] max_hits;
  logic [1:0] total_lives;
  logic [5:0] total_points;
  logic [5:0] light_flicks;
  logic [1:0] lives_left;
  logic       hit_pulse;
  logic       miss_pulse;
  logic       gameover;

  obs_t exp_q[$];
  obs_t prev = '1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  score_keeper #(
    .CNT_W(6), .KEY_W(4), .LIVES_W(2), .PENALIZE_EARLY(1'b1)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .clear        (clear),
    .start_game   (start_game),
    .light_on     (light_on),
    .light_coord  (light_coord),
    .valid_key    (valid_key),
    .key          (key),
    .max_hits     (max_hits),
    .total_lives  (total_lives),
    .total_points (total_points),
    .light_flicks (light_flicks),
    .lives_left   (lives_left),
    .hit_pulse    (hit_pulse),
    .miss_pulse   (miss_pulse),
    .gameover     (gameover)
  );

  // Monitor: every change of the output tuple must match the next queued expectation.
  always @(negedge clk) begin
    obs_t cur;
    obs_t e;
    cur = '{hit: hit_pulse, miss: miss_pulse, pts: total_points, flk: light_flicks,
            liv: lives_left, go: gameover};
    if (cur !== prev) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_change #%0d got hit=%0d miss=%0d pts=%0d flk=%0d liv=%0d go=%0d, expected no change",
                 n_vec, cur.hit, cur.miss, cur.pts, cur.flk, cur.liv, cur.go);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          n_err++;
          $display("FAIL out_vec #%0d got hit=%0d miss=%0d pts=%0d flk=%0d liv=%0d go=%0d, expected hit=%0d miss=%0d pts=%0d flk=%0d liv=%0d go=%0d",
                   n_vec, cur.hit, cur.miss, cur.pts, cur.flk, cur.liv, cur.go,
                   e.hit, e.miss, e.pts, e.flk, e.liv, e.go);
        end
      end
      prev = cur;
    end
  end

  task automatic expect_out(input logic h, input logic m, input int p, input int f,
                            input int l, input logic g);
    obs_t e;
    e = '{hit: h, miss: m, pts: p[5:0], flk: f[5:0], liv: l[1:0], go: g};
    exp_q.push_back(e);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    resetn = 1'b0; clear = 1'b0; start_game = 1'b0; light_on = 1'b0;
    light_coord = '0; valid_key = 1'b0; key = '0; max_hits = 6'd3; total_lives = 2'd0;
    expect_out(0, 0, 0, 0, 0, 0);
    step(2);
    resetn = 1'b1;
    step(1);

    // Three lights at coord 5, each hit; third fall ends the game.
    start_game = 1'b1;
    step(1);
    for (int i = 0; i < 3; i++) begin
      light_on = 1'b1; light_coord = 4'd5; step(1);
      step(1);
      valid_key = 1'b1; key = 4'd5;
      expect_out(1, 0, i + 1, i, 0, 0); step(1);
      valid_key = 1'b0;
      expect_out(0, 0, i + 1, i, 0, 0); step(1);
      light_on = 1'b0;
      expect_out(0, 0, i + 1, i + 1, 0, (i == 2)); step(1);
      step(1);
    end

    // Wrong key with one life: immediate game over, later keys ignored.
    clear = 1'b1; total_lives = 2'd1; max_hits = 6'd0;
    expect_out(0, 0, 0, 0, 0, 0); step(1);
    clear = 1'b0;
    expect_out(0, 0, 0, 0, 1, 0); step(1);
    light_on = 1'b1; light_coord = 4'd2; step(1);
    valid_key = 1'b1; key = 4'd7;
    expect_out(0, 1, 0, 0, 0, 1); step(1);
    valid_key = 1'b0;
    expect_out(0, 0, 0, 0, 0, 1); step(1);
    valid_key = 1'b1; key = 4'd2; step(1);
    valid_key = 1'b0; light_on = 1'b0; step(2);

    // New game with three lives; early key while dark costs a life only.
    clear = 1'b1; total_lives = 2'd3;
    expect_out(0, 0, 0, 0, 0, 0); step(1);
    clear = 1'b0;
    expect_out(0, 0, 0, 0, 3, 0); step(1);
    valid_key = 1'b1; key = 4'd1;
    expect_out(0, 1, 0, 0, 2, 0); step(1);
    valid_key = 1'b0;
    expect_out(0, 0, 0, 0, 2, 0); step(1);

    // Light rises and falls with no key: miss plus a flick.
    light_on = 1'b1; light_coord = 4'd4; step(2);
    light_on = 1'b0;
    expect_out(0, 1, 0, 1, 1, 0); step(1);
    expect_out(0, 0, 0, 1, 1, 0); step(1);

    // Correct key on the exact fall cycle.
    light_on = 1'b1; light_coord = 4'd9; step(2);
    light_on = 1'b0; valid_key = 1'b1; key = 4'd9;
    expect_out(1, 0, 1, 2, 1, 0); step(1);
    valid_key = 1'b0;
    expect_out(0, 0, 1, 2, 1, 0); step(1);

    // Double press in one lit window scores once.
    light_on = 1'b1; light_coord = 4'd3; step(1);
    valid_key = 1'b1; key = 4'd3;
    expect_out(1, 0, 2, 2, 1, 0); step(1);
    valid_key = 1'b0;
    expect_out(0, 0, 2, 2, 1, 0); step(1);
    valid_key = 1'b1; step(1);
    valid_key = 1'b0; light_on = 1'b0;
    expect_out(0, 0, 2, 3, 1, 0); step(1);

    // One more hit to reach three points.
    light_on = 1'b1; light_coord = 4'd6; step(1);
    valid_key = 1'b1; key = 4'd6;
    expect_out(1, 0, 3, 3, 1, 0); step(1);
    valid_key = 1'b0;
    expect_out(0, 0, 3, 3, 1, 0); step(1);
    light_on = 1'b0;
    expect_out(0, 0, 3, 4, 1, 0); step(1);

    // Pause mid-LIT: key and fall while paused change nothing.
    light_on = 1'b1; light_coord = 4'd8; step(1);
    start_game = 1'b0; step(1);
    valid_key = 1'b1; key = 4'd8; step(1);
    valid_key = 1'b0; light_on = 1'b0; step(2);
    start_game = 1'b1; light_on = 1'b1; step(1);
    valid_key = 1'b1; key = 4'd8;
    expect_out(1, 0, 4, 4, 1, 0); step(1);
    valid_key = 1'b0;
    expect_out(0, 0, 4, 4, 1, 0); step(1);
    light_on = 1'b0;
    expect_out(0, 0, 4, 5, 1, 0); step(1);

    // Asynchronous reset mid-LIT with four points.
    light_on = 1'b1; light_coord = 4'd1; step(1);
    #1;
    expect_out(0, 0, 0, 0, 0, 0);
    resetn = 1'b0;
    step(1);
    light_on = 1'b0; start_game = 1'b0; max_hits = 6'd1; total_lives = 2'd0;
    step(1);
    resetn = 1'b1; step(1);

    // One-flick budget: unanswered light ends the game, then clear returns to IDLE.
    start_game = 1'b1; step(1);
    light_on = 1'b1; light_coord = 4'd2; step(1);
    light_on = 1'b0;
    expect_out(0, 1, 0, 1, 0, 1); step(1);
    expect_out(0, 0, 0, 1, 0, 1); step(1);
    clear = 1'b1;
    expect_out(0, 0, 0, 0, 0, 0); step(1);
    clear = 1'b0; start_game = 1'b0; step(3);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_expectations got %0d left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
